// File: rtl/uart_multi_pop_tx.sv
// Drains up to N words per pop from the multi-pop TX FIFO and serializes each
// as a start bit, W data bits LSB first, and one stop bit on tx.
module uart_multi_pop_tx #(
   parameter  int W            = 8,
   parameter  int N            = 2,
   parameter  int CLKS_PER_BIT = 16,
   localparam int WN           = $clog2(N + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [WN-1:0]       can_pop,
   input  logic [N-1:0][W-1:0] pop_data,
   output logic [WN-1:0]       pop,
   output logic                tx,
   output logic                busy
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int DW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WN-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [DW-1:0]        bitn_q, bitn_d;
   logic                 tx_q, tx_d;
   logic [N-1:0][W-1:0]  word_buf_q, word_buf_d;
   logic                 baud_wrap;

   // Unsigned clamp of the FIFO's available count to the batch size.
   function automatic logic [WN-1:0] clamp_pop(input logic [WN-1:0] avail);
      if (avail > WN'(N)) return WN'(N);
      return avail;
   endfunction

   assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      baud_d     = baud_q;
      bitn_d     = bitn_q;
      word_buf_d = word_buf_q;
      pop        = '0;

      case (state_q)
         IDLE: begin
            // No words are consumed while reset is held.
            if (enable && (can_pop != '0) && !rst) begin
               pop = clamp_pop(can_pop);
               for (int i = 0; i < N; i++) begin
                  if (i < int'(pop)) word_buf_d[i] = pop_data[i];
               end
               cnt_d   = pop;
               idx_d   = '0;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            baud_d = baud_wrap ? '0 : baud_q + BW'(1);
            if (baud_wrap) begin
               bitn_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            baud_d = baud_wrap ? '0 : baud_q + BW'(1);
            if (baud_wrap) begin
               if (bitn_q == DW'(W - 1)) state_d = STOP;
               else                      bitn_d  = bitn_q + DW'(1);
            end
         end
         STOP: begin
            baud_d = baud_wrap ? '0 : baud_q + BW'(1);
            if (baud_wrap) begin
               cnt_d   = cnt_q - WN'(1);
               idx_d   = idx_q + IW'(1);
               state_d = (cnt_q != WN'(1)) ? START : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is registered from the next state so the start bit appears the
      // cycle right after the pop.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = word_buf_d[idx_d][bitn_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         baud_q  <= '0;
         bitn_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         baud_q  <= baud_d;
         bitn_q  <= bitn_d;
         tx_q    <= tx_d;
      end
   end

   // Buffered words are only meaningful while a batch is active.
   always_ff @(posedge clk) begin
      word_buf_q <= word_buf_d;
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE);

endmodule
